// File: rtl/gen_sync_pkg.sv
// Shared constants and types for the gen_sync_edge level synchronizer.
package gen_sync_pkg;

    localparam int SYNC_DP_MIN = 2;
    localparam int FILT_W_DEF  = 4;

    typedef logic [FILT_W_DEF-1:0] filt_len_t;

endpackage

// File: rtl/gen_sync_chan.sv
// One channel of gen_sync_edge: level register, edge pulse registers and,
// when GEN_SYNC_FILTER_EN is defined, the stability counter of the glitch filter.
module gen_sync_chan
    import gen_sync_pkg::*;
#(
    parameter logic RST_LVL = 1'b0
`ifdef GEN_SYNC_FILTER_EN
    ,
    parameter int   FILT_W  = $bits(filt_len_t)
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sync_i,
`ifdef GEN_SYNC_FILTER_EN
    input  logic [FILT_W-1:0] filt_len_i,
`endif
    output logic              level_o,
    output logic              rise_o,
    output logic              fall_o
);

    logic level_r, rise_r, fall_r;
    logic level_nx_s, rise_nx_s, fall_nx_s;

`ifdef GEN_SYNC_FILTER_EN
    localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1'b1);

    logic [FILT_W-1:0] cnt_r, cnt_nx_s;

    // Filter decision: commit only after the mismatch has lasted past the threshold
    always_comb begin
        level_nx_s = level_r;
        rise_nx_s  = 1'b0;
        fall_nx_s  = 1'b0;
        cnt_nx_s   = cnt_r;
        if (sync_i == level_r) begin
            cnt_nx_s = {FILT_W{1'b0}};
        end else if (cnt_r >= filt_len_i) begin
            level_nx_s = sync_i;
            rise_nx_s  = sync_i;
            fall_nx_s  = ~sync_i;
            cnt_nx_s   = {FILT_W{1'b0}};
        end else begin
            cnt_nx_s   = cnt_r + CNT_ONE;
        end
    end

    // Stability counter; cnt stays at or below L so it cannot wrap
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= {FILT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nx_s;
        end
    end
`else
    // Unfiltered: level tracks sync one register later
    always_comb begin
        level_nx_s = sync_i;
        rise_nx_s  = sync_i & ~level_r;
        fall_nx_s  = ~sync_i & level_r;
    end
`endif

    // Level and edge output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_r <= RST_LVL;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            level_r <= level_nx_s;
            rise_r  <= rise_nx_s;
            fall_r  <= fall_nx_s;
        end
    end

    assign level_o = level_r;
    assign rise_o  = rise_r;
    assign fall_o  = fall_r;

endmodule

// File: rtl/gen_sync_edge.sv
// Multi-channel synchronizer with registered level and edge pulses.
// Optional glitch filter compiled in with GEN_SYNC_FILTER_EN.
module gen_sync_edge
    import gen_sync_pkg::*;
#(
    parameter int             NCH     = 4,
    parameter int             DP      = 2,
    parameter logic [NCH-1:0] RST_VAL = '0,
    parameter int             FILT_W  = $bits(filt_len_t)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    async_i,
`ifdef GEN_SYNC_FILTER_EN
    input  logic [FILT_W-1:0] filt_len_i,
`endif
    output logic [NCH-1:0]    level_o,
    output logic [NCH-1:0]    rise_o,
    output logic [NCH-1:0]    fall_o,
    output logic              any_edge_o
);

    if (DP < SYNC_DP_MIN) begin : g_dp_check
        $error("gen_sync_edge: DP must be at least %0d", SYNC_DP_MIN);
    end
    if (FILT_W < 1) begin : g_filt_w_check
        $error("gen_sync_edge: FILT_W must be at least 1");
    end

    logic [DP-1:0][NCH-1:0] stage_r;
    logic [NCH-1:0]         sync_s;

    // Metastability chain: stage 0 samples the raw inputs, each stage shifts up
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_r <= {DP{RST_VAL}};
        end else begin
            stage_r <= {stage_r[DP-2:0], async_i};
        end
    end

    assign sync_s = stage_r[DP-1];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        gen_sync_chan #(
            .RST_LVL    (RST_VAL[i])
`ifdef GEN_SYNC_FILTER_EN
            ,
            .FILT_W     (FILT_W)
`endif
        ) u_chan (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .sync_i     (sync_s[i]),
`ifdef GEN_SYNC_FILTER_EN
            .filt_len_i (filt_len_i),
`endif
            .level_o    (level_o[i]),
            .rise_o     (rise_o[i]),
            .fall_o     (fall_o[i])
        );
    end

    // Reduction of registered pulses only, so no path from async_i
    assign any_edge_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_gen_sync_edge.sv
// Directed self-checking bench for gen_sync_edge (DP=2, DP=4, RST_VAL=4'hF,
// and the filtered channel when GEN_SYNC_FILTER_EN is defined).
module tb_gen_sync_edge;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] async_a, async_c;
    logic [3:0] level_a, rise_a, fall_a;
    logic [3:0] level_b, rise_b, fall_b;
    logic [3:0] level_c, rise_c, fall_c;
    logic       any_a, any_b, any_c;
    int         tests = 0;
    int         fails = 0;

`ifdef GEN_SYNC_FILTER_EN
    logic [3:0] async_f, len_f;
    logic [3:0] level_f, rise_f, fall_f;
    logic       any_f;
    logic [3:0] len_zero = 4'd0;
`endif

    always #5 clk = ~clk;

    gen_sync_edge #(.NCH(4), .DP(2), .RST_VAL(4'h0)) dut_a (
        .clk_i(clk), .rst_i(rst), .async_i(async_a),
`ifdef GEN_SYNC_FILTER_EN
        .filt_len_i(len_zero),
`endif
        .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a), .any_edge_o(any_a));

    gen_sync_edge #(.NCH(4), .DP(4), .RST_VAL(4'h0)) dut_b (
        .clk_i(clk), .rst_i(rst), .async_i(async_a),
`ifdef GEN_SYNC_FILTER_EN
        .filt_len_i(len_zero),
`endif
        .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b), .any_edge_o(any_b));

    gen_sync_edge #(.NCH(4), .DP(2), .RST_VAL(4'hF)) dut_c (
        .clk_i(clk), .rst_i(rst), .async_i(async_c),
`ifdef GEN_SYNC_FILTER_EN
        .filt_len_i(len_zero),
`endif
        .level_o(level_c), .rise_o(rise_c), .fall_o(fall_c), .any_edge_o(any_c));

`ifdef GEN_SYNC_FILTER_EN
    gen_sync_edge #(.NCH(4), .DP(2), .RST_VAL(4'h0)) dut_f (
        .clk_i(clk), .rst_i(rst), .async_i(async_f), .filt_len_i(len_f),
        .level_o(level_f), .rise_o(rise_f), .fall_o(fall_f), .any_edge_o(any_f));
`endif

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        async_a = 4'h0;
        async_c = 4'h0;
`ifdef GEN_SYNC_FILTER_EN
        async_f = 4'h0;
        len_f   = 4'd0;
`endif
        step();
        step();
        check("rst_level_a", level_a, 4'h0);
        check("rst_edges_a", rise_a | fall_a, 4'h0);
        check("rst_any_a", {3'b000, any_a}, 4'h0);
        check("rst_level_c", level_c, 4'hF);
        check("rst_fall_c", fall_c, 4'h0);

        // Quiet inputs for 20 cycles; dut_c reports the reset-to-low change once
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("idle_level_a", level_a, 4'h0);
            check("idle_edges_a", rise_a | fall_a | {3'b000, any_a}, 4'h0);
            check("relrst_level_c", level_c, (k >= 3) ? 4'h0 : 4'hF);
            check("relrst_fall_c", fall_c, (k == 3) ? 4'hF : 4'h0);
            check("relrst_rise_c", rise_c, 4'h0);
        end

        // Single channel rise: DP=2 on edge 3, DP=4 on edge 5
        async_a = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("rise0_level_a", level_a, (k >= 3) ? 4'b0001 : 4'b0000);
            check("rise0_rise_a", rise_a, (k == 3) ? 4'b0001 : 4'b0000);
            check("rise0_level_b", level_b, (k >= 5) ? 4'b0001 : 4'b0000);
            check("rise0_rise_b", rise_b, (k == 5) ? 4'b0001 : 4'b0000);
        end
        async_a = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("fall0_level_a", level_a, (k >= 3) ? 4'b0000 : 4'b0001);
            check("fall0_fall_a", fall_a, (k == 3) ? 4'b0001 : 4'b0000);
            check("fall0_rise_a", rise_a, 4'b0000);
            check("fall0_fall_b", fall_b, (k == 5) ? 4'b0001 : 4'b0000);
        end

        // All channels together
        async_a = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("all_rise_a", rise_a, (k == 3) ? 4'hF : 4'h0);
            check("all_any_a", {3'b000, any_a}, (k == 3) ? 4'h1 : 4'h0);
            check("all_rise_b", rise_b, (k == 5) ? 4'hF : 4'h0);
            check("all_any_b", {3'b000, any_b}, (k == 5) ? 4'h1 : 4'h0);
        end
        async_a = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("all_fall_a", fall_a, (k == 3) ? 4'hF : 4'h0);
            check("all_level_a", level_a, (k >= 3) ? 4'h0 : 4'hF);
        end

        // Toggle channel 3 every cycle: pulses every cycle, alternating
        for (int k = 1; k <= 8; k++) begin
            async_a = (k % 2 == 1) ? 4'b1000 : 4'b0000;
            step();
            if (k >= 3) begin
                check("tog_rise_a", rise_a, (k % 2 == 1) ? 4'b1000 : 4'b0000);
                check("tog_fall_a", fall_a, (k % 2 == 0) ? 4'b1000 : 4'b0000);
            end
        end
        async_a = 4'h0;
        repeat (4) step();

`ifdef GEN_SYNC_FILTER_EN
        // Filter L=3: a 3-cycle glitch is swallowed
        len_f = 4'd3;
        async_f = 4'b0010;
        repeat (3) step();
        async_f = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("glitch_level_f", level_f, 4'h0);
            check("glitch_edges_f", rise_f | fall_f, 4'h0);
        end
        // 4-cycle pulse: rise on edge 6, fall 4 cycles later
        async_f = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 4) async_f = 4'b0000;
            check("pulse_level_f", level_f, (k >= 6 && k < 10) ? 4'b0010 : 4'b0000);
            check("pulse_rise_f", rise_f, (k == 6) ? 4'b0010 : 4'b0000);
            check("pulse_fall_f", fall_f, (k == 10) ? 4'b0010 : 4'b0000);
        end
        // L=7 with count at 5, then lower L to 2: commit on the next edge
        len_f = 4'd7;
        async_f = 4'b0100;
        repeat (7) step();
        check("lowL_hold_f", level_f, 4'h0);
        len_f = 4'd2;
        step();
        check("lowL_level_f", level_f, 4'b0100);
        check("lowL_rise_f", rise_f, 4'b0100);
        // L=0 matches the unfiltered latency
        len_f = 4'd0;
        async_f = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("l0_fall_f", fall_f, (k == 3) ? 4'b0100 : 4'b0000);
        end
`endif

        // Mid-run reset clears outputs without a clock edge
        async_a = 4'hF;
        repeat (4) step();
        check("pre_rst_level_a", level_a, 4'hF);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_level_a", level_a, 4'h0);
        check("async_rst_edges_a", rise_a | fall_a, 4'h0);
        check("async_rst_level_c", level_c, 4'hF);
        async_a = 4'h0;
        step();
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
